// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
package aes_sched_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int DEF_LATENCY = 35;
    localparam int DEF_CNT_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// requester that was not served last wins.
module aes_rr_arb2 (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // Grant decode from the two valids and the last-served bit.
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (valid0_i && valid1_i) begin
            if (last_i) begin
                gnt0_o = 1'b1;
            end else begin
                gnt1_o = 1'b1;
            end
        end else if (valid0_i) begin
            gnt0_o = 1'b1;
        end else if (valid1_i) begin
            gnt1_o = 1'b1;
        end else begin
            gnt0_o = 1'b0;
            gnt1_o = 1'b0;
        end
    end

endmodule

// File: rtl/aes_job_scheduler.sv
// Feeds one AES job at a time from two requesters into an external
// fixed-latency AES core and returns the ciphertext with the requester id.
module aes_job_scheduler
    import aes_sched_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   req0_valid,
    input  logic                   req1_valid,
    output logic                   req0_ready,
    output logic                   req1_ready,
    input  logic [AES_BLOCK_W-1:0] req0_data,
    input  logic [AES_BLOCK_W-1:0] req1_data,
    input  logic [AES_BLOCK_W-1:0] req0_key,
    input  logic [AES_BLOCK_W-1:0] req1_key,
    output logic [AES_BLOCK_W-1:0] core_data_in,
    output logic [AES_BLOCK_W-1:0] core_key,
    input  logic [AES_BLOCK_W-1:0] core_data_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [AES_BLOCK_W-1:0] rsp_data,
    output logic                   rsp_id,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    sched_state_e           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   last_q, last_d;
    logic                   id_q, id_d;
    logic                   rv_q, rv_d;
    logic [AES_BLOCK_W-1:0] rdata_q, rdata_d;
    logic [AES_BLOCK_W-1:0] opd_q, opd_d;
    logic [AES_BLOCK_W-1:0] opk_q, opk_d;
    logic                   gnt0_s, gnt1_s;

    aes_rr_arb2 u_arb (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .last_i   (last_q),
        .gnt0_o   (gnt0_s),
        .gnt1_o   (gnt1_s)
    );

    // Next-state, operand capture, latency count and result capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        id_d       = id_q;
        rv_d       = rv_q;
        rdata_d    = rdata_q;
        opd_d      = opd_q;
        opk_d      = opk_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req0_ready = gnt0_s;
                req1_ready = gnt1_s;
                if (gnt0_s) begin
                    opd_d   = req0_data;
                    opk_d   = req0_key;
                    last_d  = 1'b0;
                    id_d    = 1'b0;
                    cnt_d   = CNT_ONE;
                    state_d = ST_WAIT;
                end else if (gnt1_s) begin
                    opd_d   = req1_data;
                    opk_d   = req1_key;
                    last_d  = 1'b1;
                    id_d    = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The count stops at LATENCY, so it can never wrap.
                if (cnt_q == LAT_C) begin
                    rdata_d = core_data_out;
                    rv_d    = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rv_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            rv_q    <= 1'b0;
            rdata_q <= '0;
            opd_q   <= '0;
            opk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            id_q    <= id_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
            opd_q   <= opd_d;
            opk_q   <= opk_d;
        end
    end

    assign core_data_in = opd_q;
    assign core_key     = opk_q;
    assign rsp_valid    = rv_q;
    assign rsp_data     = rdata_q;
    assign rsp_id       = id_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/aes_job_scheduler.md
AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

Interface
REQ-001 Parameter: LATENCY, default 35, core cycles from operand load to valid ciphertext; legal range 1..63.
REQ-002 Parameter: CNT_W, default 6, latency counter width; SHALL satisfy 2^CNT_W > LATENCY.
REQ-003 Port: clock  input  1  single clock for all state.
REQ-004 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-005 Ports: req0_valid/req1_valid  input  1 each  requester has a job.
REQ-006 Ports: req0_ready/req1_ready  output  1 each  job accepted this cycle.
REQ-007 Ports: req0_data/req1_data  input  128 each  plaintext.
REQ-008 Ports: req0_key/req1_key  input  128 each  key.
REQ-009 Port: core_data_in  output  128  plaintext operand to the AES core.
REQ-010 Port: core_key  output  128  key operand to the AES core.
REQ-011 Port: core_data_out  input  128  ciphertext from the AES core.
REQ-012 Port: rsp_valid  output  1  result available.
REQ-013 Port: rsp_ready  input  1  consumer takes the result.
REQ-014 Port: rsp_data  output  128  ciphertext.
REQ-015 Port: rsp_id  output  1  requester index (0/1) of the result.
REQ-016 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, WAIT, RESP; one job in flight at a time.
REQ-018 IDLE, no valid -> stay in IDLE; both req*_ready low.
REQ-019 IDLE, exactly one valid -> grant that requester, regardless of the last-served pointer.
REQ-020 IDLE, both valid -> grant the requester that is not the last-served one (round-robin).
REQ-021 req*_ready: combinational; high only in IDLE, only for the granted requester, never for both.
REQ-022 Accept edge (valid & ready): capture data/key into operand regs; set last-served pointer and rsp_id to the grant; cnt<=1; move to WAIT.
REQ-023 core_data_in/core_key come straight from the operand regs; they stay stable from acceptance until the job leaves RESP.
REQ-024 WAIT: cnt increments each cycle; the edge where cnt==LATENCY latches core_data_out into rsp_data, sets rsp_valid, and moves to RESP.
REQ-025 Latency: accept at edge T -> rsp_valid high right after edge T+LATENCY; LATENCY=1 -> capture at T+1.
REQ-026 RESP: rsp_valid, rsp_data and rsp_id hold while rsp_ready is low; no job is accepted.
REQ-027 RESP & rsp_ready -> rsp_valid<=0, go to IDLE; the next acceptance is no earlier than the following cycle.
REQ-028 Requester valid/data changes during WAIT/RESP SHALL NOT affect operands or the result.
REQ-029 Counter SHALL NOT wrap; it is reloaded only on acceptance.

Reset
REQ-030 resetn low (asynchronous) -> IDLE; rsp_valid=0; rsp_data=0; rsp_id=0; operand regs=0; cnt=0; last-served=1 (req0 wins the first tie); busy=0.
REQ-031 Reset mid-WAIT or mid-RESP aborts the job with no response; after release, behaviour equals power-up.

Structure
REQ-032 Shared package aes_sched_pkg: state enum, AES_BLOCK_W=128, default LATENCY.
REQ-033 One sub-module aes_rr_arb2: 2-way round-robin grant from two valids plus the last-served bit; combinational.
REQ-034 Scheduler instantiates the arbiter; the AES core is instantiated outside and connected through the core_* ports.

Verification
REQ-035 Bench: core model = fixed LATENCY-cycle delay line of data^key, checked against rsp_data.
REQ-036 req0 only, data=0x0011..ff, key=0x0001..0f, LATENCY=35 -> rsp_valid exactly 35 edges after acceptance; rsp_id=0; rsp_data=model.
REQ-037 Both valid from reset -> req0 served first, then req1; responses in order with rsp_id 0 then 1; never both ready.
REQ-038 rsp_ready held low 10 cycles in RESP -> rsp_data/rsp_id stable; both ready low; busy=1; on release -> IDLE.
REQ-039 resetn pulsed low at cnt==20 -> all outputs 0 immediately; no rsp_valid; next job completes normally with 35-cycle latency.
REQ-040 req1 valid continuously, req0 idle, 3 jobs -> all granted to req1; rsp_ready held high -> one acceptance every LATENCY+2 cycles.
